// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision), NUM_RD combinational
// read ports with optional write->read bypass, optional hardwired-zero entry, sequential clear.
module reg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic                    we0,
    input  logic [AW-1:0]           waddr0,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic                    we1,
    input  logic [AW-1:0]           waddr1,
    input  logic [WIDTH-1:0]        wdata1
);

    if (AW != $clog2(DEPTH)) begin : g_bad_aw
        $error("reg_file_mp: AW must equal log2(DEPTH)");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("reg_file_mp: NUM_RD must be in 1..4");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [AW-1:0]    clr_cnt, clr_cnt_next;
    logic             clear_wr, wr_en0, wr_en1;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        clear_wr     = 1'b0;
        wr_en0       = 1'b0;
        wr_en1       = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end else begin
                    wr_en0 = we0 && !(ZERO_REG != 0 && waddr0 == '0);
                    wr_en1 = we1 && !(ZERO_REG != 0 && waddr1 == '0);
                end
            end
            CLEAR: begin
                clear_wr     = 1'b1;
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CLEAR);

    // Array has no reset of its own; port 1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_wr) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (wr_en0) mem[waddr0] <= wdata0;
                if (wr_en1) mem[waddr1] <= wdata1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] lane;

        always_comb begin
            addr = rd_addr[k*AW +: AW];
            lane = mem[addr];
            if (BYPASS != 0 && we0 && waddr0 == addr) lane = wdata0;
            if (BYPASS != 0 && we1 && waddr1 == addr) lane = wdata1;
            if (state == CLEAR || (ZERO_REG != 0 && addr == '0)) lane = '0;
        end

        assign rd_data[k*WIDTH +: WIDTH] = lane;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (4 read ports, bypass and zero register enabled): a behavioural
// model checked on every cycle plus directed literal checks.
module tb_reg_file_mp;
    localparam int W = 32;
    localparam int D = 32;
    localparam int A = 5;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst, clr_req, busy;
    logic [N*A-1:0] rd_addr;
    logic [N*W-1:0] rd_data;
    logic           we0, we1;
    logic [A-1:0]   waddr0, waddr1;
    logic [W-1:0]   wdata0, wdata1;

    logic [W-1:0] m_mem [D];
    int           m_left   = 0;
    bit           checking = 1'b0;
    int           n_vec    = 0;
    int           n_err    = 0;

    reg_file_mp #(
        .WIDTH(W), .DEPTH(D), .AW(A), .NUM_RD(N), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input int k);
        return rd_data[k*W +: W];
    endfunction

    task automatic set_rd(input int k, input int addr);
        rd_addr[k*A +: A] = A'(addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: a clear blanks the array and hides it for D cycles; otherwise plain writes.
    always @(posedge clk) begin
        if (rst) begin
            m_left = D;
            foreach (m_mem[i]) m_mem[i] = '0;
            checking = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
        end else if (clr_req) begin
            m_left = D;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else begin
            if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
        end
    end

    function automatic logic [W-1:0] exp_lane(input int k);
        logic [A-1:0] a;
        a = rd_addr[k*A +: A];
        if (m_left > 0 || a == 0)     return '0;
        if (we1 && waddr1 == a)       return wdata1;
        if (we0 && waddr0 == a)       return wdata0;
        return m_mem[a];
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            check("busy", W'(busy), W'(m_left > 0));
            for (int k = 0; k < N; k++) check($sformatf("rd_lane%0d", k), lane(k), exp_lane(k));
        end
    end

    task automatic wait_idle(input string name, input int exp_cycles);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            step();
            we0 = 1'b0;
        end
        check(name, W'(n), W'(exp_cycles));
    endtask

    task automatic read_all();
        for (int base = 0; base < D; base += N) begin
            step();
            for (int k = 0; k < N; k++) set_rd(k, base + k);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; clr_req = 1'b0; rd_addr = '0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        step();
        rst = 1'b0;

        // Reset: busy for exactly D cycles, then the whole array reads zero
        wait_idle("reset_busy_cycles", 32);
        read_all();
        check("reset_addr31", lane(3), 32'h0);

        // Write with same-cycle bypass, then stored value
        step();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; set_rd(0, 5);
        @(negedge clk); check("wr_bypass", lane(0), 32'hDEADBEEF);
        step();
        we0 = 1'b0;
        @(negedge clk); check("wr_stored", lane(0), 32'hDEADBEEF);

        // Collision: port 1 wins both on bypass and in storage
        step();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22; set_rd(1, 7);
        @(negedge clk); check("coll_bypass", lane(1), 32'h22);
        step();
        we0 = 1'b0; we1 = 1'b0;
        @(negedge clk); check("coll_stored", lane(1), 32'h22);

        // Zero register ignores writes and bypass
        step();
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; set_rd(2, 0);
        @(negedge clk); check("zero_bypass", lane(2), 32'h0);
        step();
        we1 = 1'b0;
        @(negedge clk); check("zero_stored", lane(2), 32'h0);

        // Fill 1..31 with their index, using both ports with distinct addresses
        for (int i = 1; i < D; i += 2) begin
            step();
            we0 = 1'b1; waddr0 = A'(i); wdata0 = W'(i);
            we1 = (i + 1 < D); waddr1 = A'(i + 1); wdata1 = W'(i + 1);
        end
        step();
        we0 = 1'b0; we1 = 1'b0;
        set_rd(0, 3); set_rd(1, 17); set_rd(2, 31); set_rd(3, 0);
        @(negedge clk);
        check("fill_3", lane(0), 32'd3);
        check("fill_17", lane(1), 32'd17);
        check("fill_31", lane(2), 32'd31);

        // Clear request; a write issued during the clear is dropped
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3AA;
        wait_idle("clear_busy_cycles", 32);
        read_all();
        step();
        set_rd(0, 3);
        @(negedge clk); check("clear_addr3", lane(0), 32'h0);

        // Refill, start a clear, then reset on its 10th cycle
        for (int i = 1; i < D; i++) begin
            step();
            we0 = 1'b1; waddr0 = A'(i); wdata0 = W'(i * 3 + 32'h100);
        end
        step();
        we0 = 1'b0;
        set_rd(0, 10); set_rd(1, 20); set_rd(2, 30); set_rd(3, 1);
        @(negedge clk);
        check("refill_10", lane(0), 32'h11E);
        check("refill_1", lane(3), 32'h103);
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle("midclear_rst_busy_cycles", 32);
        read_all();
        step();
        set_rd(0, 10); set_rd(1, 20); set_rd(2, 30); set_rd(3, 1);
        @(negedge clk);
        for (int k = 0; k < N; k++) check($sformatf("midclear_lane%0d", k), lane(k), 32'h0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
